// File: rtl/alu_frame_loader_if.sv
// Byte-stream, ALU and result-handshake signals of alu_frame_loader.
// The slave modport is the loader's view; the master modport is its environment.
interface alu_frame_loader_if #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int NB_AB   = 4
);
  logic [NB_DATA-1:0] i_rx_data;
  logic               i_rx_valid;
  logic [NB_OP-1:0]   o_operation;
  logic [NB_AB-1:0]   o_Adata;
  logic [NB_AB-1:0]   o_Bdata;
  logic [NB_AB-1:0]   i_result;
  logic [NB_DATA-1:0] o_tx_data;
  logic               i_tx_ready;
  logic               o_tx_valid;
  logic               o_busy;
  logic               o_timeout;
  logic               o_overrun;

  modport slave (
    input  i_rx_data, i_rx_valid, i_result, i_tx_ready,
    output o_operation, o_Adata, o_Bdata, o_tx_data, o_tx_valid,
           o_busy, o_timeout, o_overrun
  );

  modport master (
    output i_rx_data, i_rx_valid, i_result, i_tx_ready,
    input  o_operation, o_Adata, o_Bdata, o_tx_data, o_tx_valid,
           o_busy, o_timeout, o_overrun
  );
endinterface

// File: rtl/alu_frame_loader.sv
// Collects A, B and opcode bytes into registered ALU inputs, captures the
// ALU result one cycle later and offers it sign-extended on a valid/ready port.
module alu_frame_loader #(
  parameter int NB_DATA = 8,
  parameter int NB_OP   = 6,
  parameter int NB_AB   = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  alu_frame_loader_if.slave    bus
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NB_AB-1:0]   a_q;
  logic [NB_AB-1:0]   b_q;
  logic [NB_OP-1:0]   op_q;
  logic [NB_DATA-1:0] tx_data_q;
  logic               tx_valid_q;
  logic               timeout_q;
  logic               overrun_q;

  logic               waiting;
  logic               expired;
  logic [NB_DATA-1:0] result_ext;

  assign waiting    = (state_q == WAIT_B) || (state_q == WAIT_OP);
  // A byte in the expiry cycle takes priority, so expiry requires silence.
  assign expired    = (TIMEOUT != 0) && waiting && !bus.i_rx_valid && (cnt_q == CNT_LAST);
  assign result_ext = NB_DATA'($signed(bus.i_result));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= WAIT_A;
      cnt_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;
      case (state_q)
        WAIT_A: begin
          cnt_q <= '0;
          if (bus.i_rx_valid) begin
            a_q     <= bus.i_rx_data[NB_AB-1:0];
            state_q <= WAIT_B;
          end
        end
        WAIT_B, WAIT_OP: begin
          if (bus.i_rx_valid) begin
            cnt_q <= '0;
            if (state_q == WAIT_B) begin
              b_q     <= bus.i_rx_data[NB_AB-1:0];
              state_q <= WAIT_OP;
            end else begin
              op_q    <= bus.i_rx_data[NB_OP-1:0];
              state_q <= EXEC;
            end
          end else if (expired) begin
            cnt_q     <= '0;
            timeout_q <= 1'b1;
            state_q   <= WAIT_A;
          end else if (TIMEOUT != 0) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        EXEC: begin
          // ALU inputs were registered last cycle, so i_result has settled.
          tx_data_q  <= result_ext;
          tx_valid_q <= 1'b1;
          overrun_q  <= bus.i_rx_valid;
          state_q    <= SEND;
        end
        SEND: begin
          overrun_q <= bus.i_rx_valid;
          if (bus.i_tx_ready) begin
            tx_valid_q <= 1'b0;
            state_q    <= WAIT_A;
          end
        end
        default: state_q <= WAIT_A;
      endcase
    end
  end

  assign bus.o_operation = op_q;
  assign bus.o_Adata     = a_q;
  assign bus.o_Bdata     = b_q;
  assign bus.o_tx_data   = tx_data_q;
  assign bus.o_tx_valid  = tx_valid_q;
  assign bus.o_busy      = (state_q == EXEC) || (state_q == SEND);
  assign bus.o_timeout   = timeout_q;
  assign bus.o_overrun   = overrun_q;

endmodule

// File: tb/tb_alu_frame_loader.sv
// Directed bench for alu_frame_loader with a small 4-bit ALU model attached
// to its operand/opcode outputs.
module tb_alu_frame_loader;
  localparam int NB_DATA = 8;
  localparam int NB_OP   = 6;
  localparam int NB_AB   = 4;
  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_frame_loader_if #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_AB(NB_AB)) bus ();

  alu_frame_loader #(.NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_AB(NB_AB), .TIMEOUT(TIMEOUT)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always_comb begin
    case (bus.o_operation)
      6'h20:   bus.i_result = bus.o_Adata + bus.o_Bdata;
      6'h22:   bus.i_result = bus.o_Adata - bus.o_Bdata;
      6'h24:   bus.i_result = bus.o_Adata & bus.o_Bdata;
      6'h25:   bus.i_result = bus.o_Adata | bus.o_Bdata;
      6'h26:   bus.i_result = bus.o_Adata ^ bus.o_Bdata;
      6'h27:   bus.i_result = ~(bus.o_Adata | bus.o_Bdata);
      default: bus.i_result = '0;
    endcase
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] exp;
    int         delay;
  } vec_t;

  vec_t vecs [9];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d);
    bus.i_rx_data  = d;
    bus.i_rx_valid = 1'b1;
    tick();
    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " tx_data"},  bus.o_tx_data,   0);
    check({tag, " tx_valid"}, bus.o_tx_valid,  0);
    check({tag, " busy"},     bus.o_busy,      0);
    check({tag, " timeout"},  bus.o_timeout,   0);
    check({tag, " overrun"},  bus.o_overrun,   0);
    check({tag, " Adata"},    bus.o_Adata,     0);
    check({tag, " Bdata"},    bus.o_Bdata,     0);
    check({tag, " op"},       bus.o_operation, 0);
  endtask

  task automatic handshake();
    bus.i_tx_ready = 1'b1;
    tick();
    bus.i_tx_ready = 1'b0;
  endtask

  // Frame with exact-cycle checks: busy at k+1, result at k+2, held while not ready.
  task automatic run_frame(input vec_t v, input string tag);
    strobe(v.a);
    strobe(v.b);
    check({tag, " Adata"}, bus.o_Adata, {28'd0, v.a[3:0]});
    check({tag, " Bdata"}, bus.o_Bdata, {28'd0, v.b[3:0]});
    strobe(v.op);
    check({tag, " op"},          bus.o_operation, {26'd0, v.op[5:0]});
    check({tag, " exec busy"},   bus.o_busy,      1);
    check({tag, " exec valid"},  bus.o_tx_valid,  0);
    tick();
    check({tag, " send valid"},  bus.o_tx_valid,  1);
    check({tag, " send data"},   bus.o_tx_data,   {24'd0, v.exp});
    for (int i = 0; i < v.delay; i++) begin
      tick();
      check($sformatf("%s hold valid %0d", tag, i), bus.o_tx_valid, 1);
      check($sformatf("%s hold data %0d", tag, i),  bus.o_tx_data,  {24'd0, v.exp});
    end
    handshake();
    check({tag, " post valid"}, bus.o_tx_valid, 0);
    check({tag, " post busy"},  bus.o_busy,     0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{a: 8'h03, b: 8'h02, op: 8'h20, exp: 8'h05, delay: 0};
    vecs[1] = '{a: 8'h02, b: 8'h05, op: 8'h22, exp: 8'hFD, delay: 10};
    vecs[2] = '{a: 8'h07, b: 8'h01, op: 8'h24, exp: 8'h01, delay: 0};
    vecs[3] = '{a: 8'h06, b: 8'h03, op: 8'h26, exp: 8'h05, delay: 1};
    vecs[4] = '{a: 8'hF3, b: 8'hA2, op: 8'hE0, exp: 8'h05, delay: 0};
    vecs[5] = '{a: 8'h07, b: 8'h01, op: 8'h20, exp: 8'hF8, delay: 2};
    vecs[6] = '{a: 8'h0A, b: 8'h05, op: 8'h25, exp: 8'hFF, delay: 0};
    vecs[7] = '{a: 8'h0A, b: 8'h05, op: 8'h27, exp: 8'h00, delay: 3};
    vecs[8] = '{a: 8'h08, b: 8'h01, op: 8'h22, exp: 8'h07, delay: 0};

    bus.i_rx_data  = '0;
    bus.i_rx_valid = 1'b0;
    bus.i_tx_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++) begin
      run_frame(vecs[i], $sformatf("v%0d", i));
    end

    // Timeout: lone A byte, pulse after TIMEOUT idle cycles.
    strobe(8'h03);
    for (int i = 1; i <= TIMEOUT; i++) begin
      check($sformatf("to quiet %0d", i), bus.o_timeout, 0);
      tick();
    end
    check("to pulse", bus.o_timeout, 1);
    check("to busy",  bus.o_busy,    0);
    check("to Akeep", bus.o_Adata,   3);
    tick();
    check("to pulse end", bus.o_timeout, 0);
    v = '{a: 8'h01, b: 8'h01, op: 8'h20, exp: 8'h02, delay: 0};
    run_frame(v, "after_to");

    // Bytes landing exactly in the expiry cycle are accepted.
    strobe(8'h04);
    repeat (TIMEOUT - 1) tick();
    strobe(8'h03);
    check("edge B timeout", bus.o_timeout, 0);
    check("edge B Bdata",   bus.o_Bdata,   3);
    repeat (TIMEOUT - 1) tick();
    strobe(8'h20);
    check("edge op timeout", bus.o_timeout, 0);
    check("edge op busy",    bus.o_busy,    1);
    tick();
    check("edge result", bus.o_tx_data, 8'h07);
    handshake();

    // Overrun in EXEC and in SEND.
    strobe(8'h0A);
    strobe(8'h05);
    strobe(8'h20);
    strobe(8'h0F);
    check("ovr exec pulse", bus.o_overrun,  1);
    check("ovr exec valid", bus.o_tx_valid, 1);
    check("ovr exec data",  bus.o_tx_data,  8'hFF);
    strobe(8'h09);
    check("ovr send pulse", bus.o_overrun,  1);
    check("ovr send data",  bus.o_tx_data,  8'hFF);
    check("ovr send Akeep", bus.o_Adata,    8'h0A);
    tick();
    check("ovr pulse end",  bus.o_overrun,  0);
    check("ovr still valid", bus.o_tx_valid, 1);
    handshake();
    v = '{a: 8'h07, b: 8'h01, op: 8'h24, exp: 8'h01, delay: 0};
    run_frame(v, "after_ovr");

    // Asynchronous reset mid-frame.
    strobe(8'h05);
    strobe(8'h04);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    tick();
    rst_n = 1'b1;
    tick();
    v = '{a: 8'h06, b: 8'h03, op: 8'h26, exp: 8'h05, delay: 0};
    run_frame(v, "after_rst");

    // Asynchronous reset while a result is pending.
    strobe(8'h03);
    strobe(8'h02);
    strobe(8'h20);
    tick();
    check("rst_send pre valid", bus.o_tx_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("rst_send");
    tick();
    rst_n = 1'b1;
    tick();
    v = '{a: 8'h02, b: 8'h05, op: 8'h22, exp: 8'hFD, delay: 0};
    run_frame(v, "after_rst_send");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_frame_loader.md
# alu_frame_loader

- Byte-stream front end that sits directly upstream of the team's combinational ALU.
- Assembles three incoming bytes (operand A, operand B, opcode) into registered ALU inputs, then captures the ALU result one cycle later.
- Returns the result, sign-extended, on a valid/ready transmit interface.
- Typical byte source is the UART receiver; typical result sink is the UART transmitter.

## Interface

- NB_DATA, 8: byte width of receive and transmit data.
- NB_OP, 6: opcode width driven to the ALU. Must be ≤ NB_DATA.
- NB_AB, 4: operand and result width of the ALU. Must be ≤ NB_DATA.
- TIMEOUT, 1000: inter-byte timeout in clock cycles. 0 disables the timeout.

- i_clk  in  1  single system clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_rx_data  in  NB_DATA  received byte.
- i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid in this cycle. No backpressure.
- o_operation  out  NB_OP  registered opcode to the ALU.
- o_Adata  out  NB_AB  registered signed operand A to the ALU.
- o_Bdata  out  NB_AB  registered signed operand B to the ALU.
- i_result  in  NB_AB  signed ALU result (combinational from o_* above).
- o_tx_data  out  NB_DATA  result sign-extended to NB_DATA.
- i_tx_ready  in  1  sink can accept o_tx_data.
- o_tx_valid  out  1  o_tx_data valid; held until accepted.
- o_busy  out  1  high in EXEC and SEND.
- o_timeout  out  1  one-cycle pulse: partial frame abandoned.
- o_overrun  out  1  one-cycle pulse: byte dropped while busy.

## Operation

- FSM states: WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND. Reset state is WAIT_A.
- WAIT_A + i_rx_valid: o_Adata <= i_rx_data[NB_AB-1:0]; go to WAIT_B.
- WAIT_B + i_rx_valid: o_Bdata <= i_rx_data[NB_AB-1:0]; go to WAIT_OP.
- WAIT_OP + i_rx_valid: o_operation <= i_rx_data[NB_OP-1:0]; go to EXEC.
- Upper unused bits of any received byte are ignored.
- EXEC, unconditional for one cycle:
  - result register <= i_result; go to SEND.
  - o_tx_data <= {sign-extension of i_result[NB_AB-1], i_result}.
- SEND: o_tx_valid = 1.
  - On i_tx_valid & i_tx_ready at a rising edge, the transfer completes; go to WAIT_A.
  - o_tx_data stays stable while waiting.
- Operand and opcode registers hold their last values until overwritten. They are not cleared between frames.
- Timeout counter, width ceil(log2(TIMEOUT+1)):
  - Counts only in WAIT_B and WAIT_OP. Cleared on any accepted byte and on entry to WAIT_A.
  - When the count reaches TIMEOUT-1 with no i_rx_valid: go to WAIT_A and pulse o_timeout for one cycle. Partially loaded registers keep their values.
  - A byte arriving in the expiry cycle wins: it is accepted and no timeout occurs.
- i_rx_valid during EXEC or SEND: byte dropped, o_overrun pulses in the next cycle, state unaffected.
- Asynchronous reset, at any time including mid-frame or mid-SEND:
  - All registers clear: o_operation, o_Adata, o_Bdata, o_tx_data = 0; o_tx_valid, o_busy, o_timeout, o_overrun = 0.
  - State returns to WAIT_A; the timeout counter clears.
  - Any pending result is discarded.

## Timing

- Registered outputs: o_operation, o_Adata, o_Bdata, o_tx_data, o_tx_valid, o_timeout, o_overrun.
- o_busy is decoded from the state register.
- Opcode byte strobed in cycle k:
  - cycle k+1: EXEC, o_busy = 1.
  - cycle k+2: o_tx_valid = 1.
- Minimum byte-to-result latency is 2 cycles. Minimum frame turnaround is 3 byte strobes + 2 cycles + the SEND handshake.
- Transfer completes at the rising edge where o_tx_valid & i_tx_ready. In the following cycle o_tx_valid = 0 and the state is WAIT_A.
- A byte strobed in that following cycle is accepted as operand A.
- i_result must settle within one cycle of o_* changing (combinational ALU).

## Test plan

- Reset: hold i_rst_n low, release -> all outputs 0, o_busy 0, first strobed byte loads o_Adata.
- ADD with NB_AB=4: bytes 0x03, 0x02, 0x20, i_tx_ready = 1 -> o_tx_valid at k+2 with o_tx_data 0x05, low the next cycle.
- SUB negative plus backpressure: bytes 0x02, 0x05, 0x22, i_tx_ready low for 10 cycles -> o_tx_data 0xFD, stable, o_tx_valid held; accepted on the first ready cycle.
- Timeout with TIMEOUT=16: byte 0x03 then silence -> o_timeout pulse 16 cycles after the byte, state WAIT_A. Then bytes 0x01, 0x01, 0x20 -> 0x02.
- Overrun: strobe a byte during SEND -> o_overrun pulse next cycle, result unchanged. Next frame 0x07, 0x01, 0x24 -> 0x01.
- Reset mid-frame: after bytes A and B, pulse i_rst_n low -> outputs 0. Frame 0x06, 0x03, 0x26 -> 0x05.
